prog_loader: RTL and testbench

Upstream boot and run controller for the 16-bit CPU. Accepts a stream of 16-bit instruction words over a valid/ready handshake and writes them into the CPU instruction memory from address 0. It then holds the CPU in reset for two cycles and issues a clock enable for a fixed cycle budget. This replaces hand-written clock loops in benches and on-board bring-up.

---
 rtl/prog_loader_pkg.sv | 19 +
 rtl/prog_loader_fsm.sv | 72 +++++++
 rtl/prog_loader.sv | 110 +++++++++++
 tb/tb_prog_loader.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg
//   Shared definitions for the program loader and the CPU it boots:
//   loader state encoding, CPU-wide instruction word width and the number
//   of cycles the CPU is held in reset before a run.
package prog_loader_pkg;

    localparam int WORD_W      = 16;
    localparam int HOLD_CYCLES = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HOLD,
        S_RUN,
        S_DONE,
        S_ERROR
    } state_t;

endpackage

// File: rtl/prog_loader_fsm.sv
// loader_fsm
//   Control for the program loader: state register, CPU reset hold counter
//   and the counter of enabled CPU run cycles.
//   Ports:
//     clk, rst_n    - clock, asynchronous active-low reset
//     start, halt   - start pulse, early-stop level
//     load_done     - last word of a good load accepted this cycle
//     load_fail     - load ended with a checksum/termination failure
//     state         - current state
//     start_take    - start accepted this cycle (datapath clears its counters)
//     run_en        - CPU clock enable, gated low while halt is high
//     cycle_count   - enabled CPU cycles in the current run
module loader_fsm
    import prog_loader_pkg::*;
#(
    parameter int RUN_CYCLES = 30
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        halt,
    input  logic        load_done,
    input  logic        load_fail,
    output state_t      state,
    output logic        start_take,
    output logic        run_en,
    output logic [15:0] cycle_count
);

    state_t     state_q;
    state_t     state_d;
    logic [1:0] hold_cnt;
    logic       run_last;

    assign state      = state_q;
    assign start_take = start && (state_q inside {S_IDLE, S_DONE, S_ERROR});
    assign run_en     = (state_q == S_RUN) && !halt;
    // Leave RUN on the edge that completes the final enabled cycle.
    assign run_last   = run_en && (cycle_count == 16'(RUN_CYCLES - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_LOAD;
            S_LOAD: begin
                if (load_fail)      state_d = S_ERROR;
                else if (load_done) state_d = S_HOLD;
            end
            S_HOLD:  if (hold_cnt == 2'(HOLD_CYCLES - 1)) state_d = S_RUN;
            S_RUN:   if (halt || run_last) state_d = S_DONE;
            S_DONE:  if (start) state_d = S_LOAD;
            S_ERROR: if (start) state_d = S_LOAD;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            hold_cnt    <= '0;
            cycle_count <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_HOLD) hold_cnt <= hold_cnt + 2'd1;
            else                   hold_cnt <= '0;
            // Count survives into DONE so the run length stays readable.
            if (state_q == S_IDLE || start_take) cycle_count <= '0;
            else if (run_en)                     cycle_count <= cycle_count + 16'd1;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// prog_loader
//   Boot and run controller for the 16-bit CPU. Streams instruction words
//   into instruction memory from address 0, holds the CPU in reset for
//   HOLD_CYCLES, then enables the CPU clock for RUN_CYCLES (or until Halt).
//   Optional feature macro: LOADER_CHECKSUM_EN -- the In_Last word becomes a
//   16-bit wrapping checksum of the preceding words instead of an
//   instruction; a mismatch or a memory-full end without In_Last goes to
//   ERROR.
//   Ports:
//     Clock, Reset_n           - clock, asynchronous active-low reset
//     Start, Halt              - load start pulse, run early-stop level
//     In_Valid/In_Ready        - word handshake; In_Data word, In_Last end
//     Mem_WE/Mem_Addr/Mem_WData- registered instruction memory write
//     Cpu_Reset_n, Cpu_Run     - CPU reset (active-low) and clock enable
//     Word_Count, Cycle_Count  - words written, enabled run cycles
//     Done, Err                - run finished, checksum failure
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int RUN_CYCLES = 30
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic              Halt,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [WORD_W-1:0] In_Data,
    input  logic              In_Last,
    output logic              Mem_WE,
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic [WORD_W-1:0] Mem_WData,
    output logic              Cpu_Reset_n,
    output logic              Cpu_Run,
    output logic [ADDR_W:0]   Word_Count,
    output logic [15:0]       Cycle_Count,
    output logic              Done,
    output logic              Err
);

    state_t state;
    logic   start_take;
    logic   accept;
    logic   at_top;
    logic   write_word;
    logic   load_done;
    logic   load_fail;
    logic   clear;

    loader_fsm #(.RUN_CYCLES(RUN_CYCLES)) u_fsm (
        .clk         (Clock),
        .rst_n       (Reset_n),
        .start       (Start),
        .halt        (Halt),
        .load_done   (load_done),
        .load_fail   (load_fail),
        .state       (state),
        .start_take  (start_take),
        .run_en      (Cpu_Run),
        .cycle_count (Cycle_Count)
    );

    assign In_Ready    = (state == S_LOAD);
    assign accept      = In_Valid && In_Ready;
    // In LOAD the count never exceeds 2^ADDR_W-1, so the low bits give the slot.
    assign at_top      = (Word_Count[ADDR_W-1:0] == '1);
    assign clear       = (state == S_IDLE) || start_take;
    // CPU stays in reset everywhere except RUN and DONE (DONE keeps it inspectable).
    assign Cpu_Reset_n = (state == S_RUN) || (state == S_DONE);
    assign Done        = (state == S_DONE);

`ifdef LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] sum;

    assign write_word = accept && !In_Last;
    assign load_done  = accept && In_Last && (In_Data == sum);
    assign load_fail  = accept && (In_Last ? (In_Data != sum) : at_top);
    assign Err        = (state == S_ERROR);

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n)        sum <= '0;
        else if (clear)      sum <= '0;
        else if (write_word) sum <= sum + In_Data;
    end
`else
    assign write_word = accept;
    assign load_done  = accept && (In_Last || at_top);
    assign load_fail  = 1'b0;
    assign Err        = 1'b0;
`endif

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            Mem_WE     <= 1'b0;
            Mem_Addr   <= '0;
            Mem_WData  <= '0;
            Word_Count <= '0;
        end else begin
            Mem_WE <= write_word;
            if (write_word) begin
                Mem_Addr  <= Word_Count[ADDR_W-1:0];
                Mem_WData <= In_Data;
            end
            if (clear)           Word_Count <= '0;
            else if (write_word) Word_Count <= Word_Count + (ADDR_W+1)'(1);
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

    logic        Clock = 1'b0;
    logic        Reset_n = 1'b0;

    // main instance: ADDR_W=8, RUN_CYCLES=30
    logic        Start = 0, Halt = 0, In_Valid = 0, In_Last = 0;
    logic [15:0] In_Data = '0;
    logic        In_Ready, Mem_WE, Cpu_Reset_n, Cpu_Run, Done, Err;
    logic [7:0]  Mem_Addr;
    logic [15:0] Mem_WData, Cycle_Count;
    logic [8:0]  Word_Count;

    // small instance: ADDR_W=2, RUN_CYCLES=5
    logic        s_Start = 0, s_Halt = 0, s_Valid = 0, s_Last = 0;
    logic [15:0] s_Data = '0;
    logic        s_Ready, s_WE, s_Cpu_Reset_n, s_Cpu_Run, s_Done, s_Err;
    logic [1:0]  s_Addr;
    logic [15:0] s_WData, s_Cycle_Count;
    logic [2:0]  s_Word_Count;

    int errors = 0;
    int checks = 0;
    logic [23:0] exp_q[$];
    logic [17:0] s_exp_q[$];
    logic [7:0]  exp_addr;
    logic [15:0] words[8];

    prog_loader #(.ADDR_W(8), .RUN_CYCLES(30)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .Start(Start), .Halt(Halt),
        .In_Valid(In_Valid), .In_Ready(In_Ready), .In_Data(In_Data), .In_Last(In_Last),
        .Mem_WE(Mem_WE), .Mem_Addr(Mem_Addr), .Mem_WData(Mem_WData),
        .Cpu_Reset_n(Cpu_Reset_n), .Cpu_Run(Cpu_Run), .Word_Count(Word_Count),
        .Cycle_Count(Cycle_Count), .Done(Done), .Err(Err)
    );

    prog_loader #(.ADDR_W(2), .RUN_CYCLES(5)) dut_small (
        .Clock(Clock), .Reset_n(Reset_n), .Start(s_Start), .Halt(s_Halt),
        .In_Valid(s_Valid), .In_Ready(s_Ready), .In_Data(s_Data), .In_Last(s_Last),
        .Mem_WE(s_WE), .Mem_Addr(s_Addr), .Mem_WData(s_WData),
        .Cpu_Reset_n(s_Cpu_Reset_n), .Cpu_Run(s_Cpu_Run), .Word_Count(s_Word_Count),
        .Cycle_Count(s_Cycle_Count), .Done(s_Done), .Err(s_Err)
    );

    always #5 Clock = ~Clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Write monitors: every observed memory write must match the oldest expected one.
    always @(negedge Clock) begin
        if (Mem_WE === 1'b1) begin
            logic [23:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL mem_write: unexpected addr 0x%0h data 0x%0h", Mem_Addr, Mem_WData);
            end else begin
                e = exp_q.pop_front();
                if ({Mem_Addr, Mem_WData} !== e) begin
                    errors++;
                    $display("FAIL mem_write: got addr 0x%0h data 0x%0h expected addr 0x%0h data 0x%0h",
                             Mem_Addr, Mem_WData, e[23:16], e[15:0]);
                end
            end
        end
    end

    always @(negedge Clock) begin
        if (s_WE === 1'b1) begin
            logic [17:0] e;
            checks++;
            if (s_exp_q.size() == 0) begin
                errors++;
                $display("FAIL small_mem_write: unexpected addr 0x%0h data 0x%0h", s_Addr, s_WData);
            end else begin
                e = s_exp_q.pop_front();
                if ({s_Addr, s_WData} !== e) begin
                    errors++;
                    $display("FAIL small_mem_write: got addr 0x%0h data 0x%0h expected addr 0x%0h data 0x%0h",
                             s_Addr, s_WData, e[17:16], e[15:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic start_load();
        exp_addr = '0;
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    // Streams words[0..n-1]; gap inserts an idle cycle before each word.
    task automatic send(input int n, input bit gap, input bit last, input bit push_last);
        for (int i = 0; i < n; i++) begin
            int w = 0;
            if (gap) begin
                In_Valid = 1'b0;
                tick();
            end
            In_Valid = 1'b1;
            In_Data  = words[i];
            In_Last  = last && (i == n - 1);
            while (!In_Ready && w < 8) begin
                tick();
                w++;
            end
            if (!In_Ready) begin
                chk("send_ready_timeout", 32'(In_Ready), 32'd1);
                break;
            end
            if (!(In_Last && !push_last)) begin
                exp_q.push_back({exp_addr, In_Data});
                exp_addr = exp_addr + 8'd1;
            end
            tick();
        end
        In_Valid = 1'b0;
        In_Last  = 1'b0;
    endtask

    // Called at the first cycle after the final accept.
    task automatic run_phase(input int halt_at, input int exp_runs);
        int lat = 1;
        int lows = 0;
        int runs = 0;
        while (!Cpu_Run && lat < 20) begin
            if (!Cpu_Reset_n) lows++;
            tick();
            lat++;
        end
        chk("accept_to_run_latency", lat, 3);
        chk("hold_reset_low_cycles", lows, 2);
        chk("cycle_count_at_run_start", 32'(Cycle_Count), 0);
        while (Cpu_Run && runs < 200) begin
            if (!Cpu_Reset_n) chk("cpu_reset_in_run", 32'(Cpu_Reset_n), 1);
            runs++;
            tick();
            if (runs == halt_at && Cpu_Run) begin
                Halt = 1'b1;
                #1;
                chk("halt_gates_cpu_run", 32'(Cpu_Run), 0);
            end
        end
        if (Halt) begin
            tick();
            Halt = 1'b0;
        end
        chk("run_cycles", runs, exp_runs);
        chk("done", 32'(Done), 1);
        chk("cycle_count_done", 32'(Cycle_Count), 32'(exp_runs));
        chk("cpu_run_done", 32'(Cpu_Run), 0);
        chk("cpu_reset_done", 32'(Cpu_Reset_n), 1);
    endtask

    initial begin
        tick();
        chk("rst_in_ready", 32'(In_Ready), 0);
        chk("rst_mem_we", 32'(Mem_WE), 0);
        chk("rst_cpu_reset_n", 32'(Cpu_Reset_n), 0);
        chk("rst_cpu_run", 32'(Cpu_Run), 0);
        chk("rst_done_err", 32'({Done, Err}), 0);
        chk("rst_counts", 32'({Word_Count, Cycle_Count}), 0);
        chk("rst_addr_data", 32'({Mem_Addr, Mem_WData}), 0);
        Reset_n = 1'b1;
        tick();

`ifndef LOADER_CHECKSUM_EN
        // Start with In_Last/In_Valid in IDLE: no word may be taken.
        In_Valid = 1'b1; In_Last = 1'b1; In_Data = 16'hDEAD;
        start_load();
        In_Valid = 1'b0; In_Last = 1'b0;
        chk("idle_start_in_ready", 32'(In_Ready), 1);
        chk("idle_start_no_word", 32'(Word_Count), 0);

        words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333;
        send(3, 1'b0, 1'b1, 1'b1);
        chk("load3_word_count", 32'(Word_Count), 3);
        chk("load3_ready_low", 32'(In_Ready), 0);
        run_phase(0, 30);

        Halt = 1'b1;
        tick();
        Halt = 1'b0;
        chk("halt_in_done_no_effect", 32'(Done), 1);

        // Reload from DONE with valid toggling, then halt after 10 run cycles.
        start_load();
        chk("reload_word_count_clear", 32'(Word_Count), 0);
        chk("reload_cycle_count_clear", 32'(Cycle_Count), 0);
        words[0] = 16'h0A0A; words[1] = 16'h0B0B; words[2] = 16'h0C0C; words[3] = 16'h0D0D;
        send(4, 1'b1, 1'b1, 1'b1);
        chk("gap_word_count", 32'(Word_Count), 4);
        run_phase(10, 10);

        // Reset in the middle of a load.
        start_load();
        words[0] = 16'h5555; words[1] = 16'h6666;
        send(2, 1'b0, 1'b0, 1'b1);
        @(negedge Clock);
        #1;
        Reset_n = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(In_Ready), 0);
        chk("midrst_mem_we", 32'(Mem_WE), 0);
        chk("midrst_addr_data", 32'({Mem_Addr, Mem_WData}), 0);
        chk("midrst_word_count", 32'(Word_Count), 0);
        chk("midrst_cpu", 32'({Cpu_Reset_n, Cpu_Run, Done, Err}), 0);
        #2;
        Reset_n = 1'b1;
        tick();
        start_load();
        words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333;
        send(3, 1'b0, 1'b1, 1'b1);
        chk("after_rst_word_count", 32'(Word_Count), 3);
        run_phase(0, 30);
`else
        // Good checksum: 0x0001 + 0x0002 = 0x0003.
        start_load();
        words[0] = 16'h0001; words[1] = 16'h0002; words[2] = 16'h0003;
        send(3, 1'b0, 1'b1, 1'b0);
        chk("cks_ok_word_count", 32'(Word_Count), 2);
        chk("cks_ok_err", 32'(Err), 0);
        run_phase(0, 30);

        // Bad checksum: run must never start.
        start_load();
        words[2] = 16'h0004;
        send(3, 1'b0, 1'b1, 1'b0);
        chk("cks_bad_err", 32'(Err), 1);
        begin
            bit saw_run = 1'b0;
            for (int i = 0; i < 40; i++) begin
                if (Cpu_Run || Cpu_Reset_n) saw_run = 1'b1;
                tick();
            end
            chk("cks_bad_no_run", 32'(saw_run), 0);
        end
        chk("cks_bad_err_held", 32'(Err), 1);
        start_load();
        chk("cks_restart_err_clear", 32'(Err), 0);
        chk("cks_restart_ready", 32'(In_Ready), 1);
`endif

        // Memory-full boundary on the ADDR_W=2 instance, no In_Last.
        s_Start = 1'b1;
        tick();
        s_Start = 1'b0;
        begin
            int acc = 0;
            int lat = 1;
            int runs = 0;
            for (int i = 0; i < 6; i++) begin
                logic [1:0] a2;
                a2 = i[1:0];
                s_Valid = 1'b1;
                s_Data  = 16'h00A0 + 16'(i);
                if (!s_Ready) break;
                s_exp_q.push_back({a2, s_Data});
                tick();
                acc++;
            end
            s_Valid = 1'b0;
            chk("full_accepts", acc, 4);
            chk("full_ready_low", 32'(s_Ready), 0);
            chk("full_word_count", 32'(s_Word_Count), 4);
`ifndef LOADER_CHECKSUM_EN
            while (!s_Cpu_Run && lat < 20) begin
                tick();
                lat++;
            end
            chk("full_run_latency", lat, 3);
            while (s_Cpu_Run && runs < 50) begin
                runs++;
                tick();
            end
            chk("full_run_cycles", runs, 5);
            chk("full_done", 32'(s_Done), 1);
            chk("full_cycle_count", 32'(s_Cycle_Count), 5);
`else
            chk("full_no_last_err", 32'(s_Err), 1);
            tick();
            chk("full_no_last_no_run", 32'(s_Cpu_Run), 0);
`endif
        end

        tick();
        chk("main_queue_drained", exp_q.size(), 0);
        chk("small_queue_drained", s_exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
